// File: rtl/regfile_pkg.sv
// Shared defaults and word type for the datapath register file.
package regfile_pkg;

    localparam int unsigned REGFILE_DATA_W = 16;
    localparam int unsigned REGFILE_ADDR_W = 3;
    localparam int unsigned REGFILE_NREGS  = 1 << REGFILE_ADDR_W;

    // Datapath word in the default configuration.
    typedef logic [REGFILE_DATA_W-1:0] word_t;

endpackage : regfile_pkg

// File: rtl/regfile_dec.sv
// Enabled binary-to-one-hot decoder used to select the write target.
module regfile_dec
    import regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = REGFILE_ADDR_W
) (
    input  logic [ADDR_W-1:0]      i_addr,
    input  logic                   i_en,
    output logic [(1<<ADDR_W)-1:0] o_sel
);

    // At most one select bit high, none when disabled.
    always_comb begin
        o_sel         = '0;
        if (i_en) begin
            o_sel[i_addr] = 1'b1;
        end
    end

endmodule : regfile_dec

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with optional write-to-read bypass,
// synchronous bulk clear and a per-register written mask.
module regfile_2r1w
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REGFILE_DATA_W,
    parameter int unsigned ADDR_W = REGFILE_ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [ADDR_W-1:0]      writenum,
    input  logic                   write,
    input  logic                   clear,
    input  logic [ADDR_W-1:0]      readnum_a,
    input  logic [ADDR_W-1:0]      readnum_b,
    output logic [DATA_W-1:0]      data_out_a,
    output logic [DATA_W-1:0]      data_out_b,
    output logic [(1<<ADDR_W)-1:0] written
);

    localparam int unsigned NREGS  = 1 << ADDR_W;
    localparam bit          BYP_EN = (BYPASS != 0);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_written;
    logic [NREGS-1:0]  w_wr_sel;
    logic              w_wr_en;
    logic              w_fwd_a;
    logic              w_fwd_b;

    // Clear wins over write, so a write during clear never reaches storage.
    assign w_wr_en = write & ~clear;

    regfile_dec #(
        .ADDR_W (ADDR_W)
    ) u_wr_dec (
        .i_addr (writenum),
        .i_en   (w_wr_en),
        .o_sel  (w_wr_sel)
    );

    // Register storage and written mask: async reset, sync clear, decoded write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_written <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_written <= '0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (w_wr_sel[i]) begin
                    r_regs[i]    <= data_in;
                    r_written[i] <= 1'b1;
                end
            end
        end
    end

    // Forward only a real write; during clear the stored value is shown.
    assign w_fwd_a = BYP_EN && w_wr_en && (readnum_a == writenum);
    assign w_fwd_b = BYP_EN && w_wr_en && (readnum_b == writenum);

    // Combinational read ports with same-cycle forwarding.
    always_comb begin
        data_out_a = r_regs[readnum_a];
        data_out_b = r_regs[readnum_b];
        if (w_fwd_a) begin
            data_out_a = data_in;
        end
        if (w_fwd_b) begin
            data_out_b = data_in;
        end
    end

    assign written = r_written;

endmodule : regfile_2r1w

// File: tb/tb_regfile_2r1w.sv
// Directed bench: default config with and without bypass, plus a 32x16 instance.
module tb_regfile_2r1w;
    import regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    word_t       data_in;
    logic [2:0]  writenum;
    logic        write;
    logic        clear;
    logic [2:0]  readnum_a;
    logic [2:0]  readnum_b;
    word_t       b1_out_a, b1_out_b, b0_out_a, b0_out_b;
    logic [7:0]  b1_written, b0_written;

    logic [31:0] w_data_in;
    logic [3:0]  w_writenum;
    logic        w_write;
    logic        w_clear;
    logic [3:0]  w_readnum_a;
    logic [3:0]  w_readnum_b;
    logic [31:0] w_out_a, w_out_b;
    logic [15:0] w_written;

    int total;
    int bad;

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .BYPASS(1)) u_b1 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum),
        .write(write), .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(b1_out_a), .data_out_b(b1_out_b), .written(b1_written)
    );

    regfile_2r1w #(.DATA_W(16), .ADDR_W(3), .BYPASS(0)) u_b0 (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .writenum(writenum),
        .write(write), .clear(clear), .readnum_a(readnum_a), .readnum_b(readnum_b),
        .data_out_a(b0_out_a), .data_out_b(b0_out_b), .written(b0_written)
    );

    regfile_2r1w #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) u_w (
        .clk(clk), .rst_n(rst_n), .data_in(w_data_in), .writenum(w_writenum),
        .write(w_write), .clear(w_clear), .readnum_a(w_readnum_a), .readnum_b(w_readnum_b),
        .data_out_a(w_out_a), .data_out_b(w_out_b), .written(w_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        #1;
        total++; if (b1_out_a !== 16'h0000) begin bad++; $display("FAIL reset_b1_a got=%h exp=%h", b1_out_a, 16'h0000); end
        total++; if (b0_out_b !== 16'h0000) begin bad++; $display("FAIL reset_b0_b got=%h exp=%h", b0_out_b, 16'h0000); end
        total++; if (b1_written !== 8'h00) begin bad++; $display("FAIL reset_written got=%h exp=%h", b1_written, 8'h00); end
        total++; if (w_written !== 16'h0000) begin bad++; $display("FAIL reset_w_written got=%h exp=%h", w_written, 16'h0000); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        write = 1'b1; writenum = 3'd0; data_in = 16'h1234;
        @(negedge clk);
        writenum = 3'd7; data_in = 16'hABCD;
        @(negedge clk);
        write = 1'b0; readnum_a = 3'd0; readnum_b = 3'd7;
        #1;
        total++; if (b1_out_a !== 16'h1234) begin bad++; $display("FAIL wr_b1_a got=%h exp=%h", b1_out_a, 16'h1234); end
        total++; if (b1_out_b !== 16'hABCD) begin bad++; $display("FAIL wr_b1_b got=%h exp=%h", b1_out_b, 16'hABCD); end
        total++; if (b0_out_a !== 16'h1234) begin bad++; $display("FAIL wr_b0_a got=%h exp=%h", b0_out_a, 16'h1234); end
        total++; if (b0_out_b !== 16'hABCD) begin bad++; $display("FAIL wr_b0_b got=%h exp=%h", b0_out_b, 16'hABCD); end
        total++; if (b1_written !== 8'h81) begin bad++; $display("FAIL wr_written got=%h exp=%h", b1_written, 8'h81); end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        write = 1'b1; writenum = 3'd5; data_in = 16'h00FF; readnum_a = 3'd5; readnum_b = 3'd7;
        #1;
        total++; if (b1_out_a !== 16'h00FF) begin bad++; $display("FAIL byp_fwd_a got=%h exp=%h", b1_out_a, 16'h00FF); end
        total++; if (b1_out_b !== 16'hABCD) begin bad++; $display("FAIL byp_nomatch_b got=%h exp=%h", b1_out_b, 16'hABCD); end
        total++; if (b0_out_a !== 16'h0000) begin bad++; $display("FAIL nobyp_old_a got=%h exp=%h", b0_out_a, 16'h0000); end
        @(negedge clk);
        write = 1'b0;
        #1;
        total++; if (b0_out_a !== 16'h00FF) begin bad++; $display("FAIL nobyp_next_a got=%h exp=%h", b0_out_a, 16'h00FF); end
        total++; if (b0_written !== 8'hA1) begin bad++; $display("FAIL byp_written got=%h exp=%h", b0_written, 8'hA1); end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear = 1'b1; write = 1'b1; writenum = 3'd2; data_in = 16'h5555;
        readnum_a = 3'd2; readnum_b = 3'd5;
        #1;
        total++; if (b1_out_a !== 16'h0000) begin bad++; $display("FAIL clr_nofwd_a got=%h exp=%h", b1_out_a, 16'h0000); end
        total++; if (b1_out_b !== 16'h00FF) begin bad++; $display("FAIL clr_stored_b got=%h exp=%h", b1_out_b, 16'h00FF); end
        @(negedge clk);
        clear = 1'b0; write = 1'b0;
        #1;
        total++; if (b1_out_a !== 16'h0000) begin bad++; $display("FAIL clr_r2 got=%h exp=%h", b1_out_a, 16'h0000); end
        total++; if (b1_out_b !== 16'h0000) begin bad++; $display("FAIL clr_r5 got=%h exp=%h", b1_out_b, 16'h0000); end
        total++; if (b1_written !== 8'h00) begin bad++; $display("FAIL clr_written got=%h exp=%h", b1_written, 8'h00); end
        total++; if (b0_written !== 8'h00) begin bad++; $display("FAIL clr_b0_written got=%h exp=%h", b0_written, 8'h00); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        write = 1'b1; writenum = 3'd1; data_in = 16'h0001; readnum_a = 3'd1; readnum_b = 3'd1;
        #1;
        total++; if (b0_out_a !== 16'h0000) begin bad++; $display("FAIL b2b_c1 got=%h exp=%h", b0_out_a, 16'h0000); end
        @(negedge clk);
        data_in = 16'h0002;
        #1;
        total++; if (b0_out_a !== 16'h0001) begin bad++; $display("FAIL b2b_c2 got=%h exp=%h", b0_out_a, 16'h0001); end
        total++; if (b1_out_b !== 16'h0002) begin bad++; $display("FAIL b2b_fwd got=%h exp=%h", b1_out_b, 16'h0002); end
        @(negedge clk);
        write = 1'b0;
        #1;
        total++; if (b0_out_b !== 16'h0002) begin bad++; $display("FAIL b2b_final got=%h exp=%h", b0_out_b, 16'h0002); end
        total++; if (b1_written !== 8'h02) begin bad++; $display("FAIL b2b_written got=%h exp=%h", b1_written, 8'h02); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        write = 1'b1; writenum = 3'd3; data_in = 16'hBEEF;
        @(negedge clk);
        write = 1'b0; readnum_a = 3'd3;
        #1;
        total++; if (b1_out_a !== 16'hBEEF) begin bad++; $display("FAIL rst_pre got=%h exp=%h", b1_out_a, 16'hBEEF); end
        write = 1'b1; writenum = 3'd4; data_in = 16'h1111;
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (b1_out_a !== 16'h0000) begin bad++; $display("FAIL rst_async_a got=%h exp=%h", b1_out_a, 16'h0000); end
        total++; if (b1_written !== 8'h00) begin bad++; $display("FAIL rst_async_written got=%h exp=%h", b1_written, 8'h00); end
        @(posedge clk);
        #1;
        readnum_b = 3'd4;
        #1;
        total++; if (b0_out_b !== 16'h0000) begin bad++; $display("FAIL rst_hold_r4 got=%h exp=%h", b0_out_b, 16'h0000); end
        total++; if (b0_written !== 8'h00) begin bad++; $display("FAIL rst_hold_written got=%h exp=%h", b0_written, 8'h00); end
        @(negedge clk);
        write = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_param();
        @(negedge clk);
        w_write = 1'b1; w_writenum = 4'd15; w_data_in = 32'hDEAD_BEEF;
        w_readnum_a = 4'd15; w_readnum_b = 4'd15;
        #1;
        total++; if (w_out_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL w_fwd_a got=%h exp=%h", w_out_a, 32'hDEAD_BEEF); end
        @(negedge clk);
        w_write = 1'b0;
        #1;
        total++; if (w_out_a !== 32'hDEAD_BEEF) begin bad++; $display("FAIL w_a got=%h exp=%h", w_out_a, 32'hDEAD_BEEF); end
        total++; if (w_out_b !== 32'hDEAD_BEEF) begin bad++; $display("FAIL w_b got=%h exp=%h", w_out_b, 32'hDEAD_BEEF); end
        total++; if (w_written !== 16'h8000) begin bad++; $display("FAIL w_written got=%h exp=%h", w_written, 16'h8000); end
        w_readnum_a = 4'd0;
        #1;
        total++; if (w_out_a !== 32'h0000_0000) begin bad++; $display("FAIL w_r0 got=%h exp=%h", w_out_a, 32'h0000_0000); end
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0;
        data_in = '0; writenum = '0; write = 1'b0; clear = 1'b0;
        readnum_a = '0; readnum_b = '0;
        w_data_in = '0; w_writenum = '0; w_write = 1'b0; w_clear = 1'b0;
        w_readnum_a = '0; w_readnum_b = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_param();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_2r1w
